// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
// Combinational definitions only: no latency, no flow control.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    FRAME = 2'd2
  } rx_state_t;

  localparam logic [3:0] BIT_IDLE       = 4'd0;
  localparam logic [3:0] BIT_START      = 4'd1;
  localparam logic [3:0] BIT_LAST_NOPAR = 4'd10;
  localparam logic [3:0] BIT_LAST_PAR   = 4'd11;

  function automatic bit prescale_ok(input int p, input int w);
    return ((p == 8) || (p == 16) || (p == 32)) && (w == $clog2(p));
  endfunction

endpackage

// File: rtl/uart_rx_majority3.sv
// Mid-bit 2-of-3 voter: two early sample flops, vote registered on the third strobe.
// sampled_bit updates one cycle after smp2; always accepts strobes, no backpressure.
module uart_rx_majority3 (
  input  logic CLK,
  input  logic RST,
  input  logic rx_s,
  input  logic smp0,
  input  logic smp1,
  input  logic smp2,
  output logic sampled_bit
);

  logic s0_q, s1_q, vote_q;

  // The third sample is taken straight from rx_s so the vote lands one cycle after it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      vote_q <= 1'b0;
    end else begin
      if (smp0) s0_q <= rx_s;
      if (smp1) s1_q <= rx_s;
      if (smp2) vote_q <= (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    end
  end

  assign sampled_bit = vote_q;

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART RX front end: synchroniser, start detect, bit timing and majority sampling.
// Start edge 3 cycles after an RX_IN fall; free-running serial input, no backpressure.
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = 8,
  parameter int EDGE_W   = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_EN,
  input  logic              PAR_EN,
  input  logic              RX_IN,
  output logic              sampled_bit,
  output logic              sample_valid,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [3:0]        bit_cnt,
  output logic              busy,
  output logic              start_glitch,
  output logic              frame_done
);

  localparam logic [EDGE_W-1:0] EDGE_MAX  = EDGE_W'(PRESCALE - 1);
  localparam logic [EDGE_W-1:0] SMP0_POS  = EDGE_W'(PRESCALE / 2 - 1);
  localparam logic [EDGE_W-1:0] SMP1_POS  = EDGE_W'(PRESCALE / 2);
  localparam logic [EDGE_W-1:0] SMP2_POS  = EDGE_W'(PRESCALE / 2 + 1);
  localparam logic [EDGE_W-1:0] VALID_POS = EDGE_W'(PRESCALE / 2 + 2);

  if (!prescale_ok(PRESCALE, EDGE_W)) begin : g_bad_prescale
    $error("uart_rx_bit_sampler: PRESCALE must be 8/16/32 and EDGE_W its log2");
  end

  logic        rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]  sync_vld_q;
  logic        armed_q, armed_d;
  rx_state_t   state_q, state_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [3:0]  bit_q, bit_d;
  logic        par_q, par_d;
  logic        in_frame, start_edge, at_valid, last_bit;
  logic        smp0, smp1, smp2;

  assign in_frame   = (state_q != IDLE);
  assign start_edge = RX_EN & armed_q & rx_prev_q & ~rx_s_q;
  // sync_vld_q keeps the reset-value 1s in the synchroniser from arming the detector.
  assign armed_d    = RX_EN & (armed_q | (sync_vld_q[1] & rx_s_q));
  assign at_valid   = in_frame & (edge_q == VALID_POS);
  assign last_bit   = (bit_q == (par_q ? BIT_LAST_PAR : BIT_LAST_NOPAR));

  assign smp0 = in_frame & RX_EN & (edge_q == SMP0_POS);
  assign smp1 = in_frame & RX_EN & (edge_q == SMP1_POS);
  assign smp2 = in_frame & RX_EN & (edge_q == SMP2_POS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= BIT_IDLE;
      par_q      <= 1'b0;
    end else begin
      rx_meta_q  <= RX_IN;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      armed_q    <= armed_d;
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      par_q      <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    par_d   = par_q;
    if (!RX_EN) begin
      state_d = IDLE;
      edge_d  = '0;
      bit_d   = BIT_IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_d = START;
            edge_d  = '0;
            bit_d   = BIT_START;
            par_d   = PAR_EN;
          end
        end
        START, FRAME: begin
          if (edge_q == EDGE_MAX) begin
            edge_d = '0;
            bit_d  = bit_q + 4'd1;
          end else begin
            edge_d = edge_q + 1'b1;
          end
          // Leaving at the stop sample re-arms detection half a bit early.
          if (at_valid) begin
            if (state_q == START) begin
              if (sampled_bit) begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = BIT_IDLE;
              end else begin
                state_d = FRAME;
              end
            end else if (last_bit) begin
              state_d = IDLE;
              edge_d  = '0;
              bit_d   = BIT_IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = BIT_IDLE;
        end
      endcase
    end
  end

  uart_rx_majority3 u_vote (
    .CLK         (CLK),
    .RST         (RST),
    .rx_s        (rx_s_q),
    .smp0        (smp0),
    .smp1        (smp1),
    .smp2        (smp2),
    .sampled_bit (sampled_bit)
  );

  assign sample_valid = at_valid;
  assign edge_cnt     = edge_q;
  assign bit_cnt      = bit_q;
  assign busy         = in_frame;
  assign start_glitch = at_valid & (state_q == START) & sampled_bit & RX_EN & ~RST;
  assign frame_done   = at_valid & (state_q == FRAME) & last_bit & RX_EN & ~RST;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Bench for uart_rx_bit_sampler: directed frames plus random traffic, every cycle
// checked against a frame-timeline model computed from the line history.
module tb_uart_rx_bit_sampler;

  localparam int P    = 8;
  localparam int EW   = 3;
  localparam int MAXC = 32768;

  logic CLK = 1'b0;
  logic RST, RX_EN, PAR_EN, RX_IN;
  logic sampled_bit, sample_valid, busy, start_glitch, frame_done;
  logic [EW-1:0] edge_cnt;
  logic [3:0] bit_cnt;

  uart_rx_bit_sampler #(.PRESCALE(P), .EDGE_W(EW)) dut (
    .CLK(CLK), .RST(RST), .RX_EN(RX_EN), .PAR_EN(PAR_EN), .RX_IN(RX_IN),
    .sampled_bit(sampled_bit), .sample_valid(sample_valid), .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt), .busy(busy), .start_glitch(start_glitch), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: line history per cycle; a frame is described by the cycle t0 of its start-bit edge 0.
  logic hist [0:MAXC-1];
  logic en_h [0:MAXC-1];
  logic par_h[0:MAXC-1];
  logic rst_h[0:MAXC-1];
  int   cyc = 0, rel = 0;
  bit   chk_en = 0;
  bit   m_busy = 0, m_par = 0, m_armed = 0, m_sbit = 0;
  int   m_t0 = 0;

  function automatic logic rxs(input int n);
    return (n >= rel + 2) ? hist[n-2] : 1'b1;
  endfunction

  always @(posedge CLK) begin
    int p, k;
    bit nxt_armed, prev_s;
    p = cyc;
    if (p >= MAXC) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", p, MAXC);
      $fatal(1);
    end
    hist[p] = RX_IN; en_h[p] = RX_EN; par_h[p] = PAR_EN; rst_h[p] = RST;
    if (rst_h[p]) begin
      m_busy = 0; m_armed = 0; m_sbit = 0; m_par = 0; rel = p + 1; chk_en = 1;
    end else begin
      nxt_armed = en_h[p] & (m_armed | ((p >= rel + 2) & rxs(p)));
      prev_s = (p > rel) ? rxs(p - 1) : 1'b1;
      if (!en_h[p]) m_busy = 0;
      else if (!m_busy) begin
        if (m_armed && prev_s && !rxs(p)) begin
          m_busy = 1; m_t0 = p + 1; m_par = par_h[p];
        end
      end else begin
        k = p - m_t0;
        if (k % P == P/2 + 1)
          m_sbit = (rxs(p-2) + rxs(p-1) + rxs(p)) >= 2;
        if (k % P == P/2 + 2 && ((k / P == 0 && m_sbit) || (1 + k / P == (m_par ? 11 : 10))))
          m_busy = 0;
      end
      m_armed = nxt_armed;
    end
    cyc = p + 1;
  end

  always @(negedge CLK) begin
    int k;
    logic [EW-1:0] e;
    logic [3:0] b;
    logic sv, gl, dn;
    if (chk_en) begin
      k = cyc - m_t0;
      e  = m_busy ? EW'(k % P) : '0;
      b  = m_busy ? 4'(1 + k / P) : 4'd0;
      sv = m_busy && (k % P == P/2 + 2);
      gl = sv && (b == 4'd1) && m_sbit && RX_EN && !RST;
      dn = sv && (b == (m_par ? 4'd11 : 4'd10)) && RX_EN && !RST;
      check("cycle_outputs",
            {20'd0, sampled_bit, sample_valid, edge_cnt, bit_cnt, busy, start_glitch, frame_done},
            {20'd0, m_sbit, sv, e, b, m_busy, gl, dn});
    end
  end

  // Frame monitor feeding the literal expectations.
  logic [7:0] cur_byte = '0;
  logic [7:0] byte_q[$];
  int done_cnt = 0, glitch_cnt = 0, max_bit = 0, last_done_bit = 0;
  bit busy_seen = 0, after_done = 0, busy_after_done = 1;

  always @(negedge CLK) begin
    int idx;
    idx = int'(bit_cnt);
    if (sample_valid && idx >= 2 && idx <= 9) cur_byte[idx-2] = sampled_bit;
    if (idx > max_bit) max_bit = idx;
    if (busy) busy_seen = 1;
    if (after_done) busy_after_done = busy;
    after_done = frame_done;
    if (frame_done) begin
      done_cnt++; last_done_bit = idx; byte_q.push_back(cur_byte);
    end
    if (start_glitch) glitch_cnt++;
  end

  task automatic hold(input logic v, input int n);
    RX_IN = v;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par, input int spk_bit, input int spk_off);
    logic [10:0] bits;
    logic v;
    int nb;
    if (par) begin bits = {1'b1, ^d, d, 1'b0}; nb = 11; end
    else begin bits = {1'b0, 1'b1, d, 1'b0}; nb = 10; end
    for (int i = 0; i < nb; i++)
      for (int c = 0; c < P; c++) begin
        v = bits[i];
        if (i == spk_bit && c == spk_off) v = ~v;
        hold(v, 1);
      end
  endtask

  function automatic logic [31:0] outs();
    return {20'd0, sampled_bit, sample_valid, edge_cnt, bit_cnt, busy, start_glitch, frame_done};
  endfunction

  initial begin
    int d0, g0;
    RST = 1'b1; RX_EN = 1'b0; PAR_EN = 1'b0; RX_IN = 1'b1;
    tick(4);
    RST = 1'b0; RX_EN = 1'b1;
    check("reset_outputs", outs(), 32'd0);
    hold(1, 2 * P);

    // 1: 0xA5, no parity
    d0 = done_cnt;
    send_frame(8'hA5, 0, -1, 0);
    hold(1, 2 * P);
    check("t1_byte", byte_q[$], 8'hA5);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_done_bit", last_done_bit, 10);
    check("t1_busy_after_done", busy_after_done, 0);

    // 2: 0x3C with parity, PAR_EN dropped mid-frame
    PAR_EN = 1'b1; max_bit = 0; d0 = done_cnt;
    fork
      send_frame(8'h3C, 1, -1, 0);
      begin tick(30); PAR_EN = 1'b0; end
    join
    hold(1, 2 * P);
    check("t2_byte", byte_q[$], 8'h3C);
    check("t2_max_bit", max_bit, 11);
    check("t2_done_bit", last_done_bit, 11);

    // 3: 2-cycle low glitch
    d0 = done_cnt; g0 = glitch_cnt;
    hold(0, 2);
    hold(1, 3 * P);
    check("t3_glitch_count", glitch_cnt - g0, 1);
    check("t3_no_done", done_cnt - d0, 0);
    check("t3_bit_cnt_idle", bit_cnt, 0);

    // 4: low spike at edge_cnt P/2 of data bit 0 (a '1')
    send_frame(8'hA5, 0, 1, P/2 + 1);
    hold(1, 2 * P);
    check("t4_spike_rejected", byte_q[$], 8'hA5);

    // 5: line low across reset release
    RX_IN = 1'b0; RST = 1'b1;
    tick(3);
    RST = 1'b0; busy_seen = 0;
    hold(0, 20);
    check("t5_no_false_start", busy_seen, 0);
    hold(1, 2 * P);
    d0 = done_cnt;
    send_frame(8'h96, 0, -1, 0);
    hold(1, 2 * P);
    check("t5_byte", byte_q[$], 8'h96);
    check("t5_done_count", done_cnt - d0, 1);

    // 6: back-to-back frames, then RX_EN abort and reset abort
    d0 = done_cnt;
    send_frame(8'h55, 0, -1, 0);
    send_frame(8'hAA, 0, -1, 0);
    hold(1, 2 * P);
    check("t6_done_count", done_cnt - d0, 2);
    check("t6_byte0", byte_q[$-1], 8'h55);
    check("t6_byte1", byte_q[$], 8'hAA);
    d0 = done_cnt;
    fork
      send_frame(8'hFF, 0, -1, 0);
      begin tick(40); RX_EN = 1'b0; tick(3); RX_EN = 1'b1; end
    join
    hold(1, 2 * P);
    check("t6_en_abort_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    fork
      send_frame(8'hFF, 0, -1, 0);
      begin
        tick(45); RST = 1'b1; tick(1); RST = 1'b0;
        check("t6_outputs_after_reset", outs(), 32'd0);
      end
    join
    hold(1, 2 * P);
    check("t6_rst_abort_no_done", done_cnt - d0, 0);

    // Random traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 30; it++) begin
      logic [7:0] d;
      bit par, drop;
      int sb, so;
      d = 8'($urandom);
      par = bit'($urandom_range(0, 1));
      PAR_EN = par;
      sb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
      so = int'($urandom_range(0, P - 1));
      drop = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) begin
        hold(0, int'($urandom_range(1, 3)));
        hold(1, 2 * P);
      end
      fork
        send_frame(d, par, sb, so);
        if (drop) begin
          tick(int'($urandom_range(5, 70))); RX_EN = 1'b0;
          tick(int'($urandom_range(1, 4))); RX_EN = 1'b1;
        end
      join
      hold(1, int'($urandom_range(0, 12)));
    end
    hold(1, 3 * P);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
